// File: rtl/riscv_core_div_pkg.sv
// Shared op codes, FSM state type and default widths for the iterative divider.
package riscv_core_div_pkg;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  localparam int DIV_XLEN = 32;
  localparam int CNT_W    = $clog2(DIV_XLEN);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

endpackage

// File: rtl/riscv_core_div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit, trial-subtract.
module riscv_core_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   p,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] d,
  output logic [XLEN:0]   p_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            unused_p_msb;

  // P stays below D, so its top bit is always clear and only the low bits shift up
  assign unused_p_msb = p[XLEN];
  assign shifted      = {p[XLEN-1:0], q[XLEN-1]};
  assign diff         = {1'b0, shifted} - {2'b00, d};

  always_comb begin
    p_next = shifted;
    q_next = {q[XLEN-2:0], 1'b0};
    if (!diff[XLEN+1]) begin
      p_next = diff[XLEN:0];
      q_next = {q[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/riscv_core_div_ctrl.sv
// Sequencing controller for the iterative M-extension divider in EX.
// Optional macro RISCV_DIV_EARLY_OUT_EN: finish immediately when |A| < |B|.
//
// state | meaning
// IDLE  | ready for a request, not stalling
// BUSY  | restoring iterations in flight, one quotient bit per cycle
// DONE  | result presented, held until downstream accepts it
module riscv_core_div_ctrl
  import riscv_core_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_div_ctrl_valid,
  input  logic [1:0]      i_div_ctrl_control,
  input  logic [XLEN-1:0] i_div_ctrl_srcA,
  input  logic [XLEN-1:0] i_div_ctrl_srcB,
  input  logic            i_div_ctrl_flush,
  input  logic            i_div_ctrl_ready,
  output logic            o_div_ctrl_ready,
  output logic            o_div_ctrl_busy,
  output logic            o_div_ctrl_valid,
  output logic [1:0]      o_div_ctrl_control,
  output logic [XLEN-1:0] o_div_ctrl_quotient,
  output logic [XLEN-1:0] o_div_ctrl_remainder,
  output logic            o_div_ctrl_srcA_sign,
  output logic            o_div_ctrl_srcB_sign
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   p_q, p_d, p_step;
  logic [XLEN-1:0] q_q, q_d, q_step;
  logic [XLEN-1:0] d_q, d_d;
  logic [1:0]      ctl_q, ctl_d;
  logic            sa_q, sa_d, sb_q, sb_d;

  logic            is_signed, sign_a, sign_b, div_zero, overflow, accept;
  logic [XLEN-1:0] mag_a, mag_b;

  assign is_signed = ~i_div_ctrl_control[0];
  assign sign_a    = is_signed & i_div_ctrl_srcA[XLEN-1];
  assign sign_b    = is_signed & i_div_ctrl_srcB[XLEN-1];
  assign mag_a     = sign_a ? -i_div_ctrl_srcA : i_div_ctrl_srcA;
  assign mag_b     = sign_b ? -i_div_ctrl_srcB : i_div_ctrl_srcB;
  assign div_zero  = (i_div_ctrl_srcB == '0);
  assign overflow  = is_signed & (i_div_ctrl_srcA == MIN_NEG) & (&i_div_ctrl_srcB);
  assign accept    = (state_q == IDLE) & i_div_ctrl_valid & ~i_div_ctrl_flush;

  riscv_core_div_step #(.XLEN(XLEN)) u_step (
    .p      (p_q),
    .q      (q_q),
    .d      (d_q),
    .p_next (p_step),
    .q_next (q_step)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      ctl_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      ctl_q   <= ctl_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    p_d              = p_q;
    q_d              = q_q;
    d_d              = d_q;
    ctl_d            = ctl_q;
    sa_d             = sa_q;
    sb_d             = sb_q;
    o_div_ctrl_ready = 1'b0;
    o_div_ctrl_busy  = 1'b0;
    o_div_ctrl_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_div_ctrl_ready = 1'b1;
        if (accept) begin
          ctl_d = i_div_ctrl_control;
          if (div_zero) begin
            q_d     = '1;
            p_d     = {1'b0, i_div_ctrl_srcA};
            sa_d    = 1'b0;
            sb_d    = 1'b0;
            state_d = DONE;
          end else if (overflow) begin
            q_d     = MIN_NEG;
            p_d     = '0;
            sa_d    = 1'b0;
            sb_d    = 1'b0;
            state_d = DONE;
          end
`ifdef RISCV_DIV_EARLY_OUT_EN
          else if (mag_a < mag_b) begin
            q_d     = '0;
            p_d     = {1'b0, mag_a};
            sa_d    = sign_a;
            sb_d    = sign_b;
            state_d = DONE;
          end
`endif
          else begin
            p_d     = '0;
            q_d     = mag_a;
            d_d     = mag_b;
            sa_d    = sign_a;
            sb_d    = sign_b;
            cnt_d   = '1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        o_div_ctrl_busy = 1'b1;
        p_d = p_step;
        q_d = q_step;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE: begin
        o_div_ctrl_busy  = 1'b1;
        o_div_ctrl_valid = 1'b1;
        if (i_div_ctrl_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a flush abandons whatever is in flight, including a result awaiting handshake
    if (i_div_ctrl_flush) state_d = IDLE;
  end

  assign o_div_ctrl_control   = ctl_q;
  assign o_div_ctrl_quotient  = q_q;
  assign o_div_ctrl_remainder = p_q[XLEN-1:0];
  assign o_div_ctrl_srcA_sign = sa_q;
  assign o_div_ctrl_srcB_sign = sb_q;

endmodule

// File: tb/tb_riscv_core_div_ctrl.sv
// Directed plus randomized bench for riscv_core_div_ctrl against an arithmetic reference model.
module tb_riscv_core_div_ctrl;
  import riscv_core_div_pkg::*;

  localparam int XLEN = 32;
`ifdef RISCV_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_div_ctrl_valid, i_div_ctrl_flush, i_div_ctrl_ready;
  logic [1:0]  i_div_ctrl_control;
  logic [31:0] i_div_ctrl_srcA, i_div_ctrl_srcB;
  logic        o_div_ctrl_ready, o_div_ctrl_busy, o_div_ctrl_valid;
  logic [1:0]  o_div_ctrl_control;
  logic [31:0] o_div_ctrl_quotient, o_div_ctrl_remainder;
  logic        o_div_ctrl_srcA_sign, o_div_ctrl_srcB_sign;

  int vectors = 0;
  int miscompares = 0;

  riscv_core_div_ctrl #(.XLEN(XLEN)) dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_div_ctrl_valid     (i_div_ctrl_valid),
    .i_div_ctrl_control   (i_div_ctrl_control),
    .i_div_ctrl_srcA      (i_div_ctrl_srcA),
    .i_div_ctrl_srcB      (i_div_ctrl_srcB),
    .i_div_ctrl_flush     (i_div_ctrl_flush),
    .i_div_ctrl_ready     (i_div_ctrl_ready),
    .o_div_ctrl_ready     (o_div_ctrl_ready),
    .o_div_ctrl_busy      (o_div_ctrl_busy),
    .o_div_ctrl_valid     (o_div_ctrl_valid),
    .o_div_ctrl_control   (o_div_ctrl_control),
    .o_div_ctrl_quotient  (o_div_ctrl_quotient),
    .o_div_ctrl_remainder (o_div_ctrl_remainder),
    .o_div_ctrl_srcA_sign (o_div_ctrl_srcA_sign),
    .o_div_ctrl_srcB_sign (o_div_ctrl_srcB_sign)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Raw outputs and architectural result from the divide rules, using plain / and %.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic sa, output logic sb, output int lat,
                       output logic [31:0] fin);
    logic        sgn, ovf;
    logic [31:0] ma, mb;
    sgn = ~op[0];
    ovf = sgn && (a == MINV) && (b == 32'hFFFF_FFFF);
    sa  = sgn & a[31];
    sb  = sgn & b[31];
    ma  = sa ? (32'd0 - a) : a;
    mb  = sb ? (32'd0 - b) : b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; sa = 1'b0; sb = 1'b0; lat = 1;
    end else if (ovf) begin
      q = MINV; r = 32'd0; sa = 1'b0; sb = 1'b0; lat = 1;
    end else begin
      q = ma / mb; r = ma % mb;
      lat = (EARLY && (ma < mb)) ? 1 : XLEN + 1;
    end
    case (op)
      DIV:     fin = (b == 0) ? 32'hFFFF_FFFF : ovf ? MINV : 32'($signed(a) / $signed(b));
      DIVU:    fin = (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:     fin = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: fin = (b == 0) ? a : a % b;
    endcase
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] eq, er, ef, res;
    logic        esa, esb;
    int          elat, lat;
    model(op, a, b, eq, er, esa, esb, elat, ef);
    @(negedge i_clk);
    check("ready_before_req", {31'd0, o_div_ctrl_ready}, 32'd1);
    i_div_ctrl_valid   = 1'b1;
    i_div_ctrl_control = op;
    i_div_ctrl_srcA    = a;
    i_div_ctrl_srcB    = b;
    @(posedge i_clk);
    #1 i_div_ctrl_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
    end while (!o_div_ctrl_valid && lat < 100);
    check("latency", 32'(lat), 32'(elat));
    check("quotient", o_div_ctrl_quotient, eq);
    check("remainder", o_div_ctrl_remainder, er);
    check("signA", {31'd0, o_div_ctrl_srcA_sign}, {31'd0, esa});
    check("signB", {31'd0, o_div_ctrl_srcB_sign}, {31'd0, esb});
    check("control", {30'd0, o_div_ctrl_control}, {30'd0, op});
    check("busy_done", {31'd0, o_div_ctrl_busy}, 32'd1);
    // emulate the divide output stage's post-negation
    if (!op[1]) res = (o_div_ctrl_srcA_sign ^ o_div_ctrl_srcB_sign) ? -o_div_ctrl_quotient : o_div_ctrl_quotient;
    else        res = o_div_ctrl_srcA_sign ? -o_div_ctrl_remainder : o_div_ctrl_remainder;
    check("final_result", res, ef);
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      check("hold_valid", {31'd0, o_div_ctrl_valid}, 32'd1);
      check("hold_busy", {31'd0, o_div_ctrl_busy}, 32'd1);
      check("hold_quotient", o_div_ctrl_quotient, eq);
      check("hold_remainder", o_div_ctrl_remainder, er);
    end
    i_div_ctrl_ready = 1'b1;
    @(posedge i_clk);
    #1 i_div_ctrl_ready = 1'b0;
    @(negedge i_clk);
    check("post_hs_valid", {31'd0, o_div_ctrl_valid}, 32'd0);
    check("post_hs_busy", {31'd0, o_div_ctrl_busy}, 32'd0);
    check("post_hs_ready", {31'd0, o_div_ctrl_ready}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return MINV;
      3:       return 32'($urandom_range(1, 15));
      4:       return 32'd0 - 32'($urandom_range(1, 15));
      5:       return 32'($urandom_range(0, 65535));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    i_rst = 1'b1;
    i_div_ctrl_valid = 1'b0;
    i_div_ctrl_flush = 1'b0;
    i_div_ctrl_ready = 1'b0;
    i_div_ctrl_control = 2'b00;
    i_div_ctrl_srcA = 32'd0;
    i_div_ctrl_srcB = 32'd0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ready", {31'd0, o_div_ctrl_ready}, 32'd1);
    check("rst_busy", {31'd0, o_div_ctrl_busy}, 32'd0);
    check("rst_valid", {31'd0, o_div_ctrl_valid}, 32'd0);
    check("rst_quotient", o_div_ctrl_quotient, 32'd0);
    check("rst_remainder", o_div_ctrl_remainder, 32'd0);
    i_rst = 1'b0;

    run_op(DIV, 32'hFFFF_FFEC, 32'd6, 0);
    run_op(DIVU, 32'hFFFF_FFFF, 32'd0, 0);
    run_op(DIV, MINV, 32'hFFFF_FFFF, 0);
    run_op(REMU, 32'd100, 32'd7, 5);

    // flush mid-operation
    @(negedge i_clk);
    i_div_ctrl_valid = 1'b1; i_div_ctrl_control = DIV;
    i_div_ctrl_srcA = 32'd50; i_div_ctrl_srcB = 32'd5;
    @(posedge i_clk);
    #1 i_div_ctrl_valid = 1'b0;
    repeat (9) @(posedge i_clk);
    #1 i_div_ctrl_flush = 1'b1;
    @(posedge i_clk);
    #1 i_div_ctrl_flush = 1'b0;
    @(negedge i_clk);
    check("flush_ready", {31'd0, o_div_ctrl_ready}, 32'd1);
    check("flush_busy", {31'd0, o_div_ctrl_busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_div_ctrl_valid) seen = 1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    run_op(DIVU, 32'd9, 32'd3, 0);

    // flush beats a request offered in IDLE
    @(negedge i_clk);
    i_div_ctrl_valid = 1'b1; i_div_ctrl_flush = 1'b1; i_div_ctrl_control = DIV;
    i_div_ctrl_srcA = 32'd50; i_div_ctrl_srcB = 32'd5;
    @(posedge i_clk);
    #1 begin i_div_ctrl_valid = 1'b0; i_div_ctrl_flush = 1'b0; end
    @(negedge i_clk);
    check("idle_flush_busy", {31'd0, o_div_ctrl_busy}, 32'd0);
    check("idle_flush_ready", {31'd0, o_div_ctrl_ready}, 32'd1);

    // flush while a result waits for the handshake
    @(negedge i_clk);
    i_div_ctrl_valid = 1'b1; i_div_ctrl_control = DIVU;
    i_div_ctrl_srcA = 32'd5; i_div_ctrl_srcB = 32'd0;
    @(posedge i_clk);
    #1 i_div_ctrl_valid = 1'b0;
    @(negedge i_clk);
    check("done_valid", {31'd0, o_div_ctrl_valid}, 32'd1);
    i_div_ctrl_flush = 1'b1;
    @(posedge i_clk);
    #1 i_div_ctrl_flush = 1'b0;
    @(negedge i_clk);
    check("done_flush_valid", {31'd0, o_div_ctrl_valid}, 32'd0);
    check("done_flush_ready", {31'd0, o_div_ctrl_ready}, 32'd1);

    // asynchronous reset mid-operation
    @(negedge i_clk);
    i_div_ctrl_valid = 1'b1; i_div_ctrl_control = DIV;
    i_div_ctrl_srcA = 32'd1000; i_div_ctrl_srcB = 32'd3;
    @(posedge i_clk);
    #1 i_div_ctrl_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1 i_rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, o_div_ctrl_ready}, 32'd1);
    check("midrst_busy", {31'd0, o_div_ctrl_busy}, 32'd0);
    check("midrst_quotient", o_div_ctrl_quotient, 32'd0);
    #1 i_rst = 1'b0;

    run_op(DIV, 32'd3, 32'hFFFF_FFF6, 0);

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      run_op(op, a, b, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_core_div_ctrl.md
Name: riscv_core_div_ctrl

Overview:
Sequencing controller for the iterative M-extension divider in the EX stage.
- Accepts one DIV/DIVU/REM/REMU request from EX, converts signed operands to magnitudes and handles divide-by-zero and overflow directly.
- Otherwise runs a radix-2 restoring division, one quotient bit per cycle.
- Presents raw quotient/remainder plus operand sign bits to the divide output stage, which applies the final negation.
- Asserts busy so the pipeline stalls EX while a division is in flight.

Parameters:
XLEN, 32, operand/result width; must be a power of two and at least 8.

Ports:
i_clk  input  1  core clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_div_ctrl_valid  input  1  request present from EX
i_div_ctrl_control  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
i_div_ctrl_srcA  input  XLEN  dividend
i_div_ctrl_srcB  input  XLEN  divisor
i_div_ctrl_flush  input  1  kill the in-flight or offered operation
i_div_ctrl_ready  input  1  downstream accepts result
o_div_ctrl_ready  output  1  request accepted this cycle when high with valid
o_div_ctrl_busy  output  1  stall request to hazard unit
o_div_ctrl_valid  output  1  result valid
o_div_ctrl_control  output  2  latched op code
o_div_ctrl_quotient  output  XLEN  unsigned quotient magnitude, or final value for special cases
o_div_ctrl_remainder  output  XLEN  unsigned remainder magnitude, or final value for special cases
o_div_ctrl_srcA_sign  output  1  dividend sign for post-negation
o_div_ctrl_srcB_sign  output  1  divisor sign for post-negation

Behaviour:
- Reset: state IDLE, count 0, all outputs 0 except o_div_ctrl_ready=1.
- States:
  - IDLE: o_ready=1, o_busy=0. A transfer occurs on valid & ready & !flush, and the block latches control.
  - Signed ops (control[0]=0): sign = operand[XLEN-1]; magnitude = two's complement when negative. |0x80..0| = 0x80..0.
  - Unsigned ops: signs 0, magnitude = operand.
  - Divisor == 0: quotient = all ones, remainder = srcA raw, signs forced 0 → DONE.
  - Signed op with srcA = 0x80..0 and srcB = all ones: quotient = 0x80..0, remainder = 0, signs forced 0 → DONE.
  - Else: partial remainder P (XLEN+1 bits) = 0, Q = |A|, D = |B|, count = XLEN-1 → BUSY.
  - BUSY: o_ready=0, o_busy=1. Each cycle: T = {P[XLEN-1:0], Q[XLEN-1]} − {0,D}; if T ≥ 0 then P=T and Q = {Q[XLEN-2:0],1}, else P = {P,Q msb} and Q = {Q,0}. At count 0 → DONE, otherwise count decrements.
  - DONE: o_valid=1, o_busy=1 until o_valid & i_ready, then → IDLE. Outputs are held stable while waiting.
- Latency:
  - Normal ops: o_valid first high XLEN+1 cycles after the accept edge (33 cycles for XLEN=32).
  - Special cases: o_valid high 1 cycle after the accept edge.
- Flush:
  - In any state, flush returns to IDLE on the next edge.
  - o_valid drops and no result is produced.
  - In IDLE with valid, flush wins and the request is not accepted.
- No back-to-back accept: the handshake in DONE and the next accept in IDLE occupy distinct cycles.
- Reset mid-operation: immediate return to IDLE, result discarded.

Optional Feature:
RISCV_DIV_EARLY_OUT_EN:
- Defined: in IDLE, a non-special request with |A| < |B| (unsigned compare of magnitudes) goes straight to DONE with quotient 0, remainder = |A| and real signs kept. Latency is 1.
- Undefined: such requests take the full XLEN iterations and yield identical results.

Decomposition:
- Package riscv_core_div_pkg holds:
  - the op localparams DIV/DIVU/REM/REMU;
  - the state enum div_state_e {IDLE, BUSY, DONE};
  - the counter width localparam CNT_W = $clog2(XLEN).
- Sub-module riscv_core_div_step: a combinational single restoring iteration, inputs P, Q, D and outputs next P and Q. It is instanced once.

Test Plan:
- DIV srcA=−20 (0xFFFFFFEC), srcB=6 → quotient 3, remainder 2, signs A=1 B=0, valid at cycle 33; after div-out stage: −3 / −2.
- DIVU srcA=0xFFFFFFFF, srcB=0 → quotient 0xFFFFFFFF, remainder 0xFFFFFFFF, signs 0, valid at cycle 1.
- DIV srcA=0x80000000, srcB=0xFFFFFFFF → quotient 0x80000000, remainder 0, signs 0, valid at cycle 1.
- REMU srcA=100, srcB=7, i_ready held low 5 cycles after valid → outputs stable with remainder 2 and quotient 14; busy=1 throughout; IDLE after the handshake.
- DIV 50/5 with flush asserted at cycle 10 → no valid, ready=1 next cycle; a new DIVU 9/3 then completes with quotient 3.
- With RISCV_DIV_EARLY_OUT_EN, DIV 3/−10 → quotient 0, remainder 3, signB=1, valid at cycle 1; without it, same values at cycle 33.
